// File: rtl/cacheline_arbiter.sv
// Two-client cacheline arbiter: muxes L1 I-side and D-side line requests onto one
// lower-level cacheline port, latching each granted command and keeping saturating perf counters.
module cacheline_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              c_read,
   output logic              c_write,
   output logic [ADDR_W-1:0] c_address,
   output logic [LINE_W-1:0] c_wdata,
   input  logic [LINE_W-1:0] c_rdata,
   input  logic              c_resp,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } state_e;

   state_e              state_q, state_d;
   logic                lastGrant_q, lastGrant_d;
   logic                cRead_q, cRead_d;
   logic                cWrite_q, cWrite_d;
   logic [ADDR_W-1:0]   cAddress_q, cAddress_d;
   logic [LINE_W-1:0]   cWdata_q, cWdata_d;
   logic [CNT_W-1:0]    iCnt_q, iCnt_d;
   logic [CNT_W-1:0]    dCnt_q, dCnt_d;
   logic [CNT_W-1:0]    conflictCnt_q, conflictCnt_d;

   logic iReq, dReq, bothReq, grantI, grantD;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // On a tie the side that did not win last time gets the port (lastGrant 0 = I, 1 = D).
   assign iReq    = i_read;
   assign dReq    = d_read | d_write;
   assign bothReq = iReq & dReq;
   assign grantI  = (state_q == IDLE) & iReq & (~dReq | lastGrant_q);
   assign grantD  = (state_q == IDLE) & dReq & (~iReq | ~lastGrant_q);

   always_comb begin
      state_d       = state_q;
      lastGrant_d   = lastGrant_q;
      cRead_d       = cRead_q;
      cWrite_d      = cWrite_q;
      cAddress_d    = cAddress_q;
      cWdata_d      = cWdata_q;
      iCnt_d        = iCnt_q;
      dCnt_d        = dCnt_q;
      conflictCnt_d = conflictCnt_q;
      case (state_q)
         IDLE: begin
            if (bothReq) begin
               conflictCnt_d = satInc(conflictCnt_q);
            end
            if (grantI) begin
               state_d     = I_BUSY;
               lastGrant_d = 1'b0;
               cRead_d     = 1'b1;
               cWrite_d    = 1'b0;
               cAddress_d  = i_address;
               iCnt_d      = satInc(iCnt_q);
            end else if (grantD) begin
               // A write wins if a misbehaving client raises both read and write.
               state_d     = D_BUSY;
               lastGrant_d = 1'b1;
               cRead_d     = d_read & ~d_write;
               cWrite_d    = d_write;
               cAddress_d  = d_address;
               cWdata_d    = d_wdata;
               dCnt_d      = satInc(dCnt_q);
            end
         end
         I_BUSY, D_BUSY: begin
            if (c_resp) begin
               state_d  = IDLE;
               cRead_d  = 1'b0;
               cWrite_d = 1'b0;
            end
         end
         default: begin
            state_d  = IDLE;
            cRead_d  = 1'b0;
            cWrite_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         lastGrant_q   <= 1'b0;
         cRead_q       <= 1'b0;
         cWrite_q      <= 1'b0;
         cAddress_q    <= '0;
         cWdata_q      <= '0;
         iCnt_q        <= '0;
         dCnt_q        <= '0;
         conflictCnt_q <= '0;
      end else begin
         state_q       <= state_d;
         lastGrant_q   <= lastGrant_d;
         cRead_q       <= cRead_d;
         cWrite_q      <= cWrite_d;
         cAddress_q    <= cAddress_d;
         cWdata_q      <= cWdata_d;
         iCnt_q        <= iCnt_d;
         dCnt_q        <= dCnt_d;
         conflictCnt_q <= conflictCnt_d;
      end
   end

   // Completion is passed straight through to the owner so the return path adds no latency.
   assign i_resp       = (state_q == I_BUSY) & c_resp;
   assign d_resp       = (state_q == D_BUSY) & c_resp;
   assign i_rdata      = c_rdata;
   assign d_rdata      = c_rdata;
   assign c_read       = cRead_q;
   assign c_write      = cWrite_q;
   assign c_address    = cAddress_q;
   assign c_wdata      = cWdata_q;
   assign i_grant_cnt  = iCnt_q;
   assign d_grant_cnt  = dCnt_q;
   assign conflict_cnt = conflictCnt_q;

endmodule
